// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns the SPI byte stream into register-bus transactions
// Byte 0 is {rw, addr}; later bytes are write data or read dummies.
module spi_reg_ctrl #(
  parameter int ADDR_W = 7,
  parameter bit AUTO_INC = 1'b1,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic              sysClk,
  input  logic              usrReset,
  input  logic              SS,
  input  logic              rxValid,
  input  logic [7:0]        rx,
  output logic [7:0]        tx,
  output logic [ADDR_W-1:0] regAddr,
  output logic [7:0]        regWrData,
  output logic              regWe,
  output logic              regRe,
  input  logic [7:0]        regRdData,
  output logic              busy,
  output logic              msgDone
);
  typedef enum logic [2:0] {IDLE, CMD, WRITE, RD_WAIT, READ} state_t;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(AUTO_INC);
  state_t state, state_n;
  logic [2:0] ss_r;
  logic ss_fall, ss_rise, we_n, re_n, done_n, re_d;
  logic [ADDR_W-1:0] addr, addr_n, ra_n;
  logic [7:0] tx_n, wd_n;
  assign busy    = ~ss_r[1];
  assign ss_fall = ss_r[2:1] == 2'b10;
  assign ss_rise = ss_r[2:1] == 2'b01;
  always_ff @(posedge sysClk or posedge usrReset)
    if (usrReset) begin
      ss_r      <= 3'b111;
      state     <= IDLE;
      addr      <= '0;
      tx        <= STATUS_BYTE;
      regAddr   <= '0;
      regWrData <= '0;
      regWe     <= 1'b0;
      regRe     <= 1'b0;
      re_d      <= 1'b0;
      msgDone   <= 1'b0;
    end else begin
      ss_r      <= {ss_r[1:0], SS};
      state     <= state_n;
      addr      <= addr_n;
      tx        <= tx_n;
      regAddr   <= ra_n;
      regWrData <= wd_n;
      regWe     <= we_n;
      regRe     <= re_n;
      re_d      <= regRe;
      msgDone   <= done_n;
    end
  // Strobes are registered from the rxValid cycle, so a byte landing with ss_rise still completes.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    ra_n    = regAddr;
    wd_n    = regWrData;
    tx_n    = tx;
    we_n    = 1'b0;
    re_n    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: tx_n = STATUS_BYTE;
      CMD:
        if (regRe) state_n = RD_WAIT;
        else if (rxValid) begin
          addr_n  = rx[ADDR_W-1:0];
          ra_n    = addr_n;
          re_n    = rx[7];
          state_n = rx[7] ? CMD : WRITE;
        end
      WRITE:
        if (rxValid) begin
          we_n   = 1'b1;
          wd_n   = rx;
          ra_n   = addr;
          addr_n = addr + INC;
        end
      RD_WAIT: begin
        tx_n    = regRdData;
        state_n = READ;
      end
      READ: begin
        tx_n = re_d ? regRdData : tx;
        if (rxValid) begin
          addr_n = addr + INC;
          ra_n   = addr_n;
          re_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (ss_rise) begin
      state_n = IDLE;
      tx_n    = STATUS_BYTE;
      done_n  = state == WRITE || state == RD_WAIT || state == READ;
    end else if (ss_fall) state_n = CMD;
  end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed checks of the SPI register controller at byte level
module tb_spi_reg_ctrl;
  logic clk = 1'b0, rst = 1'b1, ss = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx = '0, rd_data = '0, tx0, tx1, wd0, wd1;
  logic [6:0] ra0, ra1;
  logic we0, re0, busy0, done0, we1, re1, busy1, done1;
  logic [7:0] mem [128];
  int checks = 0, failures = 0, we_cnt = 0, re_cnt = 0, done_cnt = 0;
  int we_base, re_base, done_base;

  spi_reg_ctrl u0 (.sysClk(clk), .usrReset(rst), .SS(ss), .rxValid(rx_valid), .rx(rx), .tx(tx0),
    .regAddr(ra0), .regWrData(wd0), .regWe(we0), .regRe(re0), .regRdData(rd_data), .busy(busy0), .msgDone(done0));
  spi_reg_ctrl #(.AUTO_INC(1'b0)) u1 (.sysClk(clk), .usrReset(rst), .SS(ss), .rxValid(rx_valid), .rx(rx), .tx(tx1),
    .regAddr(ra1), .regWrData(wd1), .regWe(we1), .regRe(re1), .regRdData(rd_data), .busy(busy1), .msgDone(done1));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (re0) rd_data <= mem[ra0];
    if (we0) we_cnt <= we_cnt + 1;
    if (re0) re_cnt <= re_cnt + 1;
    if (done0) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send(input logic [7:0] b);
    rx = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
  endtask
  task automatic ss_low;
    ss = 1'b0; tick(4);
  endtask
  task automatic ss_high;
    ss = 1'b1; tick(3);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    mem[7'h20] = 8'hC1; mem[7'h21] = 8'hC2; mem[7'h22] = 8'hC3;
    tick(2);
    chk("rst_tx", tx0, 8'hA5); chk("rst_addr", ra0, 0); chk("rst_wd", wd0, 0);
    chk("rst_we", we0, 0); chk("rst_re", re0, 0); chk("rst_busy", busy0, 0); chk("rst_done", done0, 0);
    rst = 1'b0; tick(2);

    // 1: write burst
    we_base = we_cnt; done_base = done_cnt;
    ss_low(); chk("w_busy", busy0, 1);
    send(8'h10); chk("w_cmd_we", we0, 0);
    send(8'h11); chk("w1_we", we0, 1); chk("w1_addr", ra0, 7'h10); chk("w1_data", wd0, 8'h11);
    tick(); chk("w1_we_pulse", we0, 0);
    send(8'h22); chk("w2_addr", ra0, 7'h11); chk("w2_data", wd0, 8'h22);
    send(8'h33); chk("w3_addr", ra0, 7'h12); chk("w3_data", wd0, 8'h33);
    tick(2);
    ss_high(); chk("w_done", done0, 1); chk("w_busy_end", busy0, 0);
    tick(); chk("w_done_pulse", done0, 0);
    chk("w_we_count", we_cnt - we_base, 3); chk("w_done_count", done_cnt - done_base, 1);

    // 2: read burst
    re_base = re_cnt;
    ss_low(); chk("r_tx0", tx0, 8'hA5);
    send(8'hA0); chk("r0_re", re0, 1); chk("r0_addr", ra0, 7'h20); chk("r0_we", we0, 0);
    tick(2); chk("r_tx1", tx0, 8'hC1);
    send(8'h00); chk("r1_addr", ra0, 7'h21);
    tick(2); chk("r_tx2", tx0, 8'hC2);
    send(8'h00); chk("r2_addr", ra0, 7'h22);
    tick(2); chk("r_tx3", tx0, 8'hC3);
    send(8'h00); chk("r3_re", re0, 1); chk("r3_addr", ra0, 7'h23);
    tick(3);
    ss_high(); chk("r_done", done0, 1); chk("r_tx_status", tx0, 8'hA5);
    chk("r_re_count", re_cnt - re_base, 4);

    // 3: wrap-around and held address
    ss_low();
    send(8'h7F);
    send(8'hAA); chk("wrap1_addr", ra0, 7'h7F); chk("hold1_addr", ra1, 7'h7F); chk("hold1_we", we1, 1);
    send(8'hBB); chk("wrap2_addr", ra0, 7'h00); chk("wrap2_data", wd0, 8'hBB); chk("hold2_addr", ra1, 7'h7F);
    tick(2); ss_high(); tick();

    // 4: abort on a partial data byte
    we_base = we_cnt;
    ss_low(); send(8'h40); tick(5);
    ss_high(); tick();
    chk("abort_we", we_cnt - we_base, 0); chk("abort_tx", tx0, 8'hA5); chk("abort_busy", busy0, 0);

    // 5: command-only messages; rxValid lands with ss_rise
    we_base = we_cnt; re_base = re_cnt; done_base = done_cnt;
    ss_low(); ss = 1'b1; tick(2);
    send(8'h05); tick(3);
    chk("c5_strobes", (we_cnt - we_base) + (re_cnt - re_base), 0); chk("c5_done", done_cnt - done_base, 0);
    ss_low(); ss = 1'b1; tick(2);
    send(8'h85); chk("c85_re", re0, 1); chk("c85_addr", ra0, 7'h05);
    tick(3);
    chk("c85_re_count", re_cnt - re_base, 1); chk("c85_done", done_cnt - done_base, 0); chk("c85_tx", tx0, 8'hA5);

    // 6: asynchronous reset mid-read, then a clean write
    ss_low(); send(8'hA1); tick(3);
    send(8'h00); chk("rr_re", re0, 1);
    rst = 1'b1; #1;
    chk("rr_re_clr", re0, 0); chk("rr_tx", tx0, 8'hA5); chk("rr_addr", ra0, 0); chk("rr_busy", busy0, 0);
    tick(); rst = 1'b0; tick();
    ss = 1'b1; tick(2);
    ss_low(); send(8'h30); send(8'h44);
    chk("post_we", we0, 1); chk("post_addr", ra0, 7'h30); chk("post_data", wd0, 8'h44);
    tick(2); ss_high(); tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
